axi4lite_mem_master: RTL and testbench
======================================

Name: axi4lite_mem_master

Overview:
- AXI4-lite initiator that turns the core's single-outstanding memory request interface (IFU/LSU side) into AXI4-lite transactions toward the UART/memory slave.
- Handles one transaction at a time, read or write, and returns a one-cycle response pulse carrying read data and an error flag.
- Sits between the core's memory-access stage and the AXI4-lite interconnect or slave.

Parameters:
- ADDR_W, 32, address width of the request and AXI address channels.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous reset, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  master can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  write byte mask.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_W  read data; 0 for writes.
- resp_err  out  1  1 when the response code is SLVERR or DECERR.
- awvalid/awready/awaddr  out/in/out  1/1/ADDR_W  AXI write address channel.
- wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_W/DATA_W/8  AXI write data channel.
- bvalid/bready/bresp  in/out/in  1/1/2  AXI write response channel.
- arvalid/arready/araddr  out/in/out  1/1/ADDR_W  AXI read address channel.
- rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_W/2  AXI read data channel.

Behaviour:
- Clocking and reset: single clock aclk. Reset is asynchronous and active-high on areset.
- Reset values: state IDLE; all AXI valid/ready outputs 0; resp_valid 0; resp_rdata 0; resp_err 0; address/data/strobe registers 0.
- All outputs are registered, except req_ready = (state==IDLE).
- Request accept: req_valid && req_ready latches addr, wdata, wstrb and wen.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE: on accept, go to RD_ADDR (wen=0) or WR_REQ (wen=1).
- RD_ADDR: arvalid=1 with araddr held stable. On arvalid && arready, clear arvalid, set rready=1 and go to RD_DATA.
  - An arready already high in the first RD_ADDR cycle completes the handshake in that cycle.
- RD_DATA: rvalid is sampled only in this state. Any rvalid before the AR handshake is ignored.
  - On rvalid && rready: clear rready, capture rdata into resp_rdata, set resp_err = rresp[1], pulse resp_valid and go to IDLE.
- WR_REQ: awvalid and wvalid rise together on entry.
  - Each is cleared independently the cycle after its own handshake. Either order, or both in the same cycle, is legal.
  - When both handshakes are done (done flags awdone/wdone), set bready=1 and go to WR_RESP.
  - Valids are never dropped before their ready, and addr/data/strb stay stable while valid.
- WR_RESP: on bvalid && bready, clear bready, set resp_err = bresp[1], set resp_rdata=0, pulse resp_valid and go to IDLE.
- resp_valid is high for exactly one cycle, the first cycle back in IDLE. There is no backpressure on the response; the core must consume it.
- Back-to-back: a new request may be accepted in the same cycle resp_valid is high.
- Zero-wait read latency: accept at cycle 0, AR handshake at cycle 1, R handshake at cycle 2, resp_valid at cycle 3.
- Zero-wait write latency: accept at cycle 0, AW+W handshakes at cycle 1, B handshake at cycle 2, resp_valid at cycle 3.
- Response codes: OKAY (00) and EXOKAY (01) give err=0. SLVERR (10) and DECERR (11) give err=1.
- Reset mid-transaction: all valids and readies drop immediately, state returns to IDLE, and no resp_valid is produced.

Optional Feature:
- Macro: AXI_MASTER_ALIGN_CHECK_EN.
- Defined:
  - A request whose req_addr[1:0] != 0 issues no AXI traffic.
  - The FSM goes IDLE to IDLE, with resp_valid=1, resp_err=1 and resp_rdata=0 on the next cycle.
  - The request is still accepted, and req_ready stays high.
- Undefined: addresses pass through unchanged; alignment is the slave's concern.

Decomposition:
- Package axi4lite_pkg holds:
  - Response code constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - The master FSM state enum.
  - The default widths.
- No sub-module is needed: the module is a single FSM plus per-channel done flags.

Test Plan:
- Read, slave with arready=1 and rvalid one cycle after AR, rdata=32'hDEADBEEF, rresp=00 -> resp_valid at cycle 3, resp_rdata=DEADBEEF, resp_err=0; arvalid high exactly 1 cycle.
- Write addr=32'h8000_0010, wdata=32'h1234_5678, wstrb=4'b0011; slave asserts wready 3 cycles before awready -> wvalid drops after its handshake while awvalid holds; bready rises only after both handshakes; bresp=00 gives resp_err=0.
- Read with rresp=2'b10 and 4-cycle arready stall -> araddr stable for all 4 cycles; resp_err=1.
- Back-to-back: a write followed by a read accepted in the resp_valid cycle -> second arvalid one cycle later; no lost or duplicated response.
- areset asserted while in WR_REQ with awvalid=1 -> all outputs 0 immediately, state IDLE, req_ready=1, no resp_valid.
- With AXI_MASTER_ALIGN_CHECK_EN: read at 32'h8000_0002 -> no arvalid ever, resp_valid with resp_err=1 one cycle after accept.

Source files
------------

// File: rtl/axi4lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_pkg
// Brief    : Shared AXI4-lite response codes, default widths and master FSM
//            state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package axi4lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } mst_state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4lite_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_mem_master
// Brief    : Single-outstanding core memory request -> AXI4-lite initiator.
//            Optional AXI_MASTER_ALIGN_CHECK_EN rejects misaligned requests.
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_mem_master
  import axi4lite_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_W-1:0]     araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp
);

  mst_state_t            r_state, w_state;
  logic [ADDR_W-1:0]     r_addr, w_addr;
  logic [DATA_W-1:0]     r_wdata, w_wdata;
  logic [DATA_W/8-1:0]   r_wstrb, w_wstrb;
  logic                  r_awdone, w_awdone;
  logic                  r_wdone, w_wdone;
  logic                  w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready;
  logic                  w_resp_valid, w_resp_err;
  logic [DATA_W-1:0]     w_resp_rdata;

  assign req_ready = (r_state == IDLE);
  assign awaddr    = r_addr;
  assign araddr    = r_addr;
  assign wdata     = r_wdata;
  assign wstrb     = r_wstrb;

  always_comb begin
    w_state      = r_state;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_wstrb      = r_wstrb;
    w_awdone     = r_awdone;
    w_wdone      = r_wdone;
    w_arvalid    = arvalid;
    w_rready     = rready;
    w_awvalid    = awvalid;
    w_wvalid     = wvalid;
    w_bready     = bready;
    w_resp_valid = 1'b0;
    w_resp_rdata = resp_rdata;
    w_resp_err   = resp_err;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_addr  = req_addr;
          w_wdata = req_wdata;
          w_wstrb = req_wstrb;
`ifdef AXI_MASTER_ALIGN_CHECK_EN
          // Misaligned requests are answered locally with an error, no bus traffic.
          if (req_addr[1:0] != 2'b00) begin
            w_resp_valid = 1'b1;
            w_resp_err   = 1'b1;
            w_resp_rdata = '0;
          end else
`endif
          if (req_wen) begin
            w_state   = WR_REQ;
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
            w_awdone  = 1'b0;
            w_wdone   = 1'b0;
          end else begin
            w_state   = RD_ADDR;
            w_arvalid = 1'b1;
          end
        end
      end
      RD_ADDR: begin
        if (arready) begin
          w_arvalid = 1'b0;
          w_rready  = 1'b1;
          w_state   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          w_rready     = 1'b0;
          w_resp_rdata = rdata;
          w_resp_err   = resp_is_err(rresp);
          w_resp_valid = 1'b1;
          w_state      = IDLE;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; B is opened once both are done.
        if (awvalid && awready) begin
          w_awvalid = 1'b0;
          w_awdone  = 1'b1;
        end
        if (wvalid && wready) begin
          w_wvalid = 1'b0;
          w_wdone  = 1'b1;
        end
        if (w_awdone && w_wdone) begin
          w_bready = 1'b1;
          w_state  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          w_bready     = 1'b0;
          w_resp_rdata = '0;
          w_resp_err   = resp_is_err(bresp);
          w_resp_valid = 1'b1;
          w_state      = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_awdone   <= 1'b0;
      r_wdone    <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_wstrb    <= w_wstrb;
      r_awdone   <= w_awdone;
      r_wdone    <= w_wdone;
      arvalid    <= w_arvalid;
      rready     <= w_rready;
      awvalid    <= w_awvalid;
      wvalid     <= w_wvalid;
      bready     <= w_bready;
      resp_valid <= w_resp_valid;
      resp_rdata <= w_resp_rdata;
      resp_err   <= w_resp_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4lite_mem_master
// Brief    : Scoreboard bench for axi4lite_mem_master with a memory slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4lite_mem_master;
  import axi4lite_pkg::*;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready;
  logic [1:0]  bresp = '0;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [31:0] araddr, rdata = '0;
  logic [1:0]  rresp = '0;

  always #5 aclk = ~aclk;

  axi4lite_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;     // accept-to-response cycles, -1 = unchecked
    int          ar_cnt;  // cycles arvalid is high, -1 = unchecked
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  int          checks = 0, errors = 0, cyc = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] slv_mem [64];
  int          ar_wait = 0, aw_wait = 0, w_wait = 0, r_delay = 0, b_delay = 0;
  bit          spur_en = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave address map: region nibble selects the response code.
  function automatic logic [1:0] code_of(input logic [31:0] a);
    case (a[31:28])
      4'hE:    return RESP_SLVERR;
      4'hF:    return RESP_DECERR;
      4'h9:    return RESP_EXOKAY;
      default: return RESP_OKAY;
    endcase
  endfunction

  function automatic logic [31:0] err_data(input logic [31:0] a);
    return 32'hBAD0_0000 | {24'h0, 2'b00, a[7:2]};
  endfunction

  function automatic exp_t predict(input logic wen, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [3:0] strb, input bit latchk);
    exp_t e;
    logic [5:0] idx = addr[7:2];
    logic [1:0] code = code_of(addr);
    e.err    = (code == RESP_SLVERR) || (code == RESP_DECERR);
    e.lat    = latchk ? 3 : -1;
    e.ar_cnt = (latchk && !wen) ? 1 : -1;
`ifdef AXI_MASTER_ALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) begin
      e.rdata = '0; e.err = 1'b1;
      e.lat = latchk ? 1 : -1; e.ar_cnt = latchk ? 0 : -1;
      return e;
    end
`endif
    if (wen) begin
      if (!e.err)
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
      e.rdata = '0;
    end else begin
      e.rdata = e.err ? err_data(addr) : ref_mem[idx];
    end
    return e;
  endfunction

  // ---------------- AXI4-lite memory slave ----------------
  int          arcnt = 0, awcnt = 0, wcnt = 0, rcnt = 0, bcnt = 0;
  bit          rd_pend = 0, r_real = 0, aw_got = 0, w_got = 0, b_pend = 0, b_real = 0;
  logic [31:0] rd_addr = '0, wa = '0, wd = '0;
  logic [3:0]  ws = '0;
  logic [1:0]  rd_code = '0, b_code = '0;

  always @(posedge aclk) begin
    if (areset) begin
      arcnt = 0; awcnt = 0; wcnt = 0; rcnt = 0; bcnt = 0;
      rd_pend = 0; r_real = 0; aw_got = 0; w_got = 0; b_pend = 0; b_real = 0;
    end else begin
      if (arvalid && arready) begin
        rd_pend = 1; r_real = 0; rcnt = 0; rd_addr = araddr; rd_code = code_of(araddr);
      end
      if (rvalid && rready) begin rd_pend = 0; r_real = 0; end
      if (awvalid && awready) begin aw_got = 1; wa = awaddr; end
      if (wvalid && wready) begin w_got = 1; wd = wdata; ws = wstrb; end
      if (bvalid && bready) begin b_pend = 0; b_real = 0; end
      if (aw_got && w_got) begin
        b_code = code_of(wa);
        if (!b_code[1])
          for (int b = 0; b < 4; b++)
            if (ws[b]) slv_mem[wa[7:2]][b*8 +: 8] = wd[b*8 +: 8];
        b_pend = 1; bcnt = 0; aw_got = 0; w_got = 0;
      end
      arcnt = (arvalid && !arready) ? arcnt + 1 : 0;
      awcnt = (awvalid && !awready) ? awcnt + 1 : 0;
      wcnt  = (wvalid && !wready) ? wcnt + 1 : 0;
    end
    #1;
    if (areset) begin
      arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    end else begin
      arready = arvalid && (arcnt >= ar_wait);
      awready = awvalid && (awcnt >= aw_wait);
      wready  = wvalid && (wcnt >= w_wait);
      if (rd_pend && !r_real) begin
        if (rcnt >= r_delay) begin
          r_real = 1; rresp = rd_code;
          rdata = rd_code[1] ? err_data(rd_addr) : slv_mem[rd_addr[7:2]];
        end else rcnt++;
      end
      // Garbage rvalid while the address phase is still open must be ignored.
      if (r_real) rvalid = 1;
      else if (spur_en && arvalid && $urandom_range(0, 2) == 0) begin
        rvalid = 1; rdata = $urandom; rresp = 2'($urandom);
      end else rvalid = 0;
      if (b_pend && !b_real) begin
        if (bcnt >= b_delay) begin b_real = 1; bresp = b_code; end
        else bcnt++;
      end
      bvalid = b_real;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
  logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
  logic [3:0]  p_wstrb = '0;
  bit          m_ar = 0, m_aw = 0, m_w = 0;
  int          ar_hi = 0;

  always @(negedge aclk) begin
    exp_t e;
    int   a;
    if (areset) begin
      p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
      m_ar = 0; m_aw = 0; m_w = 0; ar_hi = 0;
    end else begin
      if (p_arv && !p_arr) begin
        check("arvalid_hold", 32'(arvalid), 32'd1);
        check("araddr_stable", araddr, p_araddr);
      end
      if (p_arv && p_arr) check("arvalid_drop", 32'(arvalid), 32'd0);
      if (p_awv && !p_awr) begin
        check("awvalid_hold", 32'(awvalid), 32'd1);
        check("awaddr_stable", awaddr, p_awaddr);
      end
      if (p_awv && p_awr) check("awvalid_drop", 32'(awvalid), 32'd0);
      if (p_wv && !p_wr) begin
        check("wvalid_hold", 32'(wvalid), 32'd1);
        check("wdata_stable", wdata, p_wdata);
        check("wstrb_stable", 32'(wstrb), 32'(p_wstrb));
      end
      if (p_wv && p_wr) check("wvalid_drop", 32'(wvalid), 32'd0);
      if (bready) check("bready_after_aw_w", 32'({m_aw, m_w}), 32'd3);
      if (rready) check("rready_after_ar", 32'(m_ar), 32'd1);
      if (arvalid) ar_hi++;
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", 32'(resp_err), 32'(e.err));
          if (e.lat >= 0) check("resp_latency", cyc - a, e.lat);
          if (e.ar_cnt >= 0) check("arvalid_cycles", ar_hi, e.ar_cnt);
        end
      end
      if (arvalid && arready) m_ar = 1;
      if (awvalid && awready) m_aw = 1;
      if (wvalid && wready) m_w = 1;
      if (req_valid && req_ready) begin
        acc_q.push_back(cyc); ar_hi = 0; m_ar = 0; m_aw = 0; m_w = 0;
      end
      p_arv = arvalid; p_arr = arready; p_araddr = araddr;
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_waits(input int arw, input int aww, input int ww, input int rd, input int bd);
    ar_wait = arw; aw_wait = aww; w_wait = ww; r_delay = rd; b_delay = bd;
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input bit latchk);
    int n = 0;
    exp_q.push_back(predict(wen, addr, wd, strb, latchk));
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = strb;
    @(negedge aclk);
    while (!req_ready && n < 400) begin @(negedge aclk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready got 0 expected 1");
    end
    @(posedge aclk); #1;
    req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge aclk); n++; end
    @(posedge aclk); #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
      slv_mem[i] = ref_mem[i];
    end
    ref_mem[1] = 32'hDEADBEEF;
    slv_mem[1] = 32'hDEADBEEF;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_ctrl", 32'({awvalid, wvalid, bready, arvalid, rready, resp_valid, resp_err}), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_addr", araddr, 32'd0);
    areset = 0;
    @(posedge aclk); #1;

    // zero-wait read of DEADBEEF
    set_waits(0, 0, 0, 0, 0); spur_en = 0;
    issue(1'b0, 32'h8000_0004, 32'h0, 4'h0, 1);
    drain();
    // write with W accepted three cycles ahead of AW, then read back the merge
    set_waits(0, 3, 0, 0, 0);
    issue(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 0);
    drain();
    set_waits(0, 0, 0, 0, 0);
    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, 1);
    drain();
    // SLVERR read behind a 4-cycle address stall
    set_waits(4, 0, 0, 0, 0);
    issue(1'b0, 32'hE000_0020, 32'h0, 4'h0, 0);
    drain();
    // back-to-back write then read
    set_waits(0, 0, 0, 0, 0);
    issue(1'b1, 32'h8000_0030, 32'h0BAD_CAFE, 4'hF, 1);
    issue(1'b0, 32'h8000_0030, 32'h0, 4'h0, 1);
    drain();
    // misaligned read
    issue(1'b0, 32'h8000_0002, 32'h0, 4'h0, 1);
    drain();

    // randomized traffic
    spur_en = 1;
    for (int t = 0; t < 40; t++) begin
      logic [3:0]  region;
      logic [31:0] addr;
      int          gap;
      case ($urandom_range(0, 5))
        0: region = 4'h9;
        1: region = 4'hE;
        2: region = 4'hF;
        default: region = 4'h8;
      endcase
      addr = {region, 20'h0, 6'($urandom_range(0, 31)),
              ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00};
      set_waits($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      issue(1'($urandom), addr, $urandom, 4'($urandom), 0);
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge aclk); #1; end
    end
    drain();

    // reset while a write is stalled in the address/data phase
    spur_en = 0;
    set_waits(0, 20, 20, 0, 0);
    issue(1'b1, 32'h8000_00FC, 32'hCAFE_F00D, 4'hF, 0);
    @(posedge aclk); #1;
    check("pre_rst_awvalid", 32'(awvalid), 32'd1);
    areset = 1;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("midrst_ctrl", 32'({awvalid, wvalid, bready, arvalid, rready, resp_valid, resp_err}), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_awaddr", awaddr, 32'd0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 0;
    set_waits(0, 0, 0, 0, 0);
    repeat (8) @(posedge aclk);
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    issue(1'b0, 32'h8000_00A0, 32'h0, 4'h0, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
